ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch_pkg.sv | 30 +++
 rtl/ifu_fifo.sv | 81 ++++++++
 rtl/ifu_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
// Shared constants and types for the instruction fetch unit:
//   XLEN / INST_W    - address and instruction widths
//   RESET_PC_DEFAULT - default first fetch address after reset
//   fetch_state_e    - fetch FSM state encoding (REQ / WAIT / DROP)
//   fetch_entry_t    - one buffered instruction {pc, data}
//   word_align()     - clears the two low address bits
package ifu_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // issue a request when the buffer has room
    ST_WAIT = 2'd1,  // one live request outstanding
    ST_DROP = 2'd2   // one stale request outstanding, its response is discarded
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo
// Small synchronous FIFO holding fetched instructions for decode.
// Ports:
//   clk, rst (async active-low)
//   clear      - empties the FIFO on the next edge (wins over push/pop)
//   push       - write push_data (ignored when full and not popping)
//   pop        - drop head entry (ignored when empty)
//   head       - current head entry
//   count      - number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
    push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
  end

  // Storage array; cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch
// Instruction fetch unit: issues sequential word fetches to instruction
// memory (one outstanding at a time) and buffers the returned
// instructions with their PCs for decode. A BPU flush redirects the PC,
// empties the buffer and turns any outstanding request into a stale one
// whose response is dropped.
// Ports:
//   clk, rst (async active-low)
//   bpu_clear_ctrl, redirect_pc        - flush / redirect request
//   imem_req_valid/ready/addr          - fetch request channel
//   imem_rsp_valid/data                - fetch response (no backpressure)
//   inst_valid/ready, inst_pc/data     - buffered instruction to decode
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bpu_clear_ctrl,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_e      state_r;
  fetch_state_e      state_s;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   pc_seq_s;
  logic [XLEN-1:0]   pc_s;
  logic [XLEN-1:0]   req_pc_r;
  logic [XLEN-1:0]   req_pc_s;
  logic              push_s;
  logic              pop_s;
  logic              accept_s;
  logic              has_room_s;
  logic [CNT_W-1:0]  count_s;
  fetch_entry_t      head_s;
  fetch_entry_t      push_entry_s;

  // Requests are only offered in REQ with buffer room, and never in reset,
  // so every response that can arrive always has a slot waiting for it.
  assign has_room_s     = (count_s < FULL_CNT);
  assign imem_req_valid = rst && (state_r == ST_REQ) && has_room_s;
  assign imem_req_addr  = pc_r;
  assign accept_s       = imem_req_valid && imem_req_ready;

  // Next state, sequential PC, request PC latch and buffer push.
  always_comb begin
    state_s  = state_r;
    pc_seq_s = pc_r;
    req_pc_s = req_pc_r;
    push_s   = 1'b0;
    case (state_r)
      ST_REQ: begin
        if (accept_s) begin
          if (bpu_clear_ctrl) begin
            // Request left the building but is already stale.
            state_s = ST_DROP;
          end else begin
            state_s  = ST_WAIT;
            req_pc_s = pc_r;
            pc_seq_s = pc_r + 32'd4;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_s = ST_REQ;
          push_s  = !bpu_clear_ctrl;
        end else if (bpu_clear_ctrl) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_REQ;
      end
    endcase
  end

  // A flush overrides whatever sequential PC update was computed.
  assign pc_s = bpu_clear_ctrl ? word_align(redirect_pc) : pc_seq_s;

  // Pop is suppressed during a flush; the buffer is cleared instead.
  assign pop_s = inst_valid && inst_ready && !bpu_clear_ctrl;

  // FSM state, fetch PC and outstanding-request PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_REQ;
      pc_r     <= RESET_PC;
      req_pc_r <= {XLEN{1'b0}};
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
    end
  end

  assign push_entry_s = '{pc: req_pc_r, data: imem_rsp_data};

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (bpu_clear_ctrl),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  assign inst_valid = (count_s != {CNT_W{1'b0}});
  assign inst_pc    = head_s.pc;
  assign inst_data  = head_s.data;

endmodule
